// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Serialises bitstream words LSB-first into one ccff chain and
//               gates config_enable for exactly CHAIN_LEN shifts.
//               Optional CCFF_VERIFY_EN adds a CRC-checked loopback pass.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 4,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int               AVL_W     = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CHAIN_LEN);
  localparam logic [AVL_W-1:0] WORD_REST = AVL_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [AVL_W-1:0]  avail_q, avail_d;
  logic              head_q, head_d;
  logic              cfg_en_q, cfg_en_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;

`ifdef CCFF_VERIFY_EN
  logic [15:0] crc_a_q, crc_a_d;
  logic [15:0] crc_b_q, crc_b_d;
  logic [15:0] crc_b_nx;
  logic        err_q, err_d;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    avail_d     = avail_q;
    head_d      = head_q;
    cfg_en_d    = 1'b0;
    bit_count_d = bit_count_q;
    s_ready     = 1'b0;
`ifdef CCFF_VERIFY_EN
    crc_a_d     = crc_a_q;
    crc_b_d     = crc_b_q;
    crc_b_nx    = crc_step(crc_b_q, ccff_tail);
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          bit_count_d = '0;
          avail_d     = '0;
`ifdef CCFF_VERIFY_EN
          crc_a_d     = 16'hFFFF;
          crc_b_d     = 16'hFFFF;
          err_d       = 1'b0;
`endif
        end
      end
      S_LOAD: begin
`ifdef CCFF_VERIFY_EN
        if (cfg_en_q) crc_a_d = crc_step(crc_a_q, head_q);
`endif
        // bit_count tracks the bit on ccff_head now, so LAST_CNT marks the final shift
        if (bit_count_q == LAST_CNT) begin
          avail_d = '0;
`ifdef CCFF_VERIFY_EN
          state_d     = S_VERIFY;
          cfg_en_d    = 1'b1;
          bit_count_d = CNT_W'(1);
`else
          state_d     = S_DONE;
`endif
        end else begin
          s_ready = (avail_q == '0);
          if (avail_q != '0) begin
            head_d      = word_q[0];
            word_d      = word_q >> 1;
            avail_d     = avail_q - AVL_W'(1);
            cfg_en_d    = 1'b1;
            bit_count_d = bit_count_q + CNT_W'(1);
          end else if (s_valid) begin
            head_d      = s_data[0];
            word_d      = s_data >> 1;
            avail_d     = WORD_REST;
            cfg_en_d    = 1'b1;
            bit_count_d = bit_count_q + CNT_W'(1);
          end
        end
      end
`ifdef CCFF_VERIFY_EN
      S_VERIFY: begin
        crc_b_d = crc_b_nx;
        if (bit_count_q == LAST_CNT) begin
          state_d = S_DONE;
          err_d   = (crc_a_q != crc_b_nx);
        end else begin
          cfg_en_d    = 1'b1;
          bit_count_d = bit_count_q + CNT_W'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      avail_q     <= '0;
      head_q      <= 1'b0;
      cfg_en_q    <= 1'b0;
      bit_count_q <= '0;
`ifdef CCFF_VERIFY_EN
      crc_a_q     <= 16'hFFFF;
      crc_b_q     <= 16'hFFFF;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      avail_q     <= avail_d;
      head_q      <= head_d;
      cfg_en_q    <= cfg_en_d;
      bit_count_q <= bit_count_d;
`ifdef CCFF_VERIFY_EN
      crc_a_q     <= crc_a_d;
      crc_b_q     <= crc_b_d;
      err_q       <= err_d;
`endif
    end
  end

  assign config_enable = cfg_en_q;
  assign bit_count     = bit_count_q;
  assign busy          = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign done          = (state_q == S_DONE);

`ifdef CCFF_VERIFY_EN
  // Loopback must present the tail bit of this very cycle, so it bypasses head_q
  assign ccff_head = (state_q == S_VERIFY) ? ccff_tail : head_q;
  assign err       = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign ccff_head   = head_q;
  assign err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// tb_ccff_chain_loader: drives a 4-bit and a 12-bit chain loader against a
// queue-based model of the expected bit stream and final chain contents.
module tb_ccff_chain_loader;

  localparam int LEN0 = 4;
  localparam int LEN1 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       pReset, start, s_valid, s_ready, ccff_head, config_enable;
  logic [1:0]       ccff_tail, busy, done, err;
  logic [1:0]       force0;
  logic [1:0][7:0]  s_data;
  logic [2:0]       bc0;
  logic [3:0]       bc1;
  logic [1:0][11:0] chain = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] plan[$];

  ccff_chain_loader #(.CHAIN_LEN(LEN0), .WORD_W(8)) u_dut0 (
    .prog_clk(clk), .pReset(pReset[0]), .start(start[0]), .s_data(s_data[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .ccff_head(ccff_head[0]),
    .config_enable(config_enable[0]), .ccff_tail(ccff_tail[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .bit_count(bc0)
  );

  ccff_chain_loader #(.CHAIN_LEN(LEN1), .WORD_W(8)) u_dut1 (
    .prog_clk(clk), .pReset(pReset[1]), .start(start[1]), .s_data(s_data[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .ccff_head(ccff_head[1]),
    .config_enable(config_enable[1]), .ccff_tail(ccff_tail[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .bit_count(bc1)
  );

  // Chain model: bit 0 is the flop nearest ccff_head
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (config_enable[i]) chain[i] <= {chain[i][10:0], ccff_head[i]};
  end
  assign ccff_tail[0] = force0[0] ? 1'b0 : chain[0][LEN0-1];
  assign ccff_tail[1] = force0[1] ? 1'b0 : chain[1][LEN1-1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int get_bc(input int idx);
    return (idx == 0) ? int'(bc0) : int'(bc1);
  endfunction

  task automatic run_load(input int idx, input int gap, input bit rand_gap,
                          input bit pulse_start, input bit force_t, input int rst_after);
    int len, need_words, wi, gap_left, nshift, nce, first_ce, last_ce, done_cyc, accepted;
    bit exp_bits[$];
    bit got_done, any_one;
    logic [11:0] exp_chain, mask;
    len = (idx == 0) ? LEN0 : LEN1;
    exp_bits.delete();
    foreach (plan[w])
      for (int b = 0; b < 8; b++)
        if (exp_bits.size() < len) exp_bits.push_back(plan[w][b]);
    exp_chain = '0;
    any_one   = 1'b0;
    for (int i = 0; i < len; i++) begin
      exp_chain[i] = exp_bits[len-1-i];
      any_one      = any_one | exp_bits[i];
    end
    mask       = 12'((1 << len) - 1);
    need_words = (len + 7) / 8;
    wi = 0; gap_left = 0; nshift = 0; nce = 0; first_ce = 0; last_ce = 0;
    done_cyc = 0; accepted = 0; got_done = 1'b0;
    force0[idx] = force_t;

    @(negedge clk);
    start[idx]   = 1'b1;
    s_valid[idx] = 1'b1;
    s_data[idx]  = plan[0];
    @(negedge clk);
    start[idx] = 1'b0;
    check_eq("start_busy", 32'(busy[idx]), 32'd1);
    check_eq("start_bc", 32'(get_bc(idx)), 32'd0);

    for (int cyc = 0; cyc < 300; cyc++) begin
      if (config_enable[idx]) begin
        if (nshift < len) begin
          check_eq("head_bit", 32'(ccff_head[idx]), 32'(exp_bits[nshift]));
          check_eq("bc_load", 32'(get_bc(idx)), 32'(nshift + 1));
        end else begin
          check_eq("loopback", 32'(ccff_head[idx]), 32'(ccff_tail[idx]));
          check_eq("bc_verify", 32'(get_bc(idx)), 32'(nshift - len + 1));
        end
        if (nce == 0) first_ce = cyc;
        last_ce = cyc;
        nce++;
        nshift++;
      end
      if (done[idx]) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (rst_after > 0 && nshift == rst_after) begin
        pReset[idx]  = 1'b1;
        start[idx]   = 1'b0;
        s_valid[idx] = 1'b0;
        @(negedge clk);
        check_eq("rst_mid", 32'({config_enable[idx], busy[idx], done[idx]}), 32'd0);
        check_eq("rst_mid_bc", 32'(get_bc(idx)), 32'd0);
        pReset[idx] = 1'b0;
        force0[idx] = 1'b0;
        @(negedge clk);
        check_eq("rst_no_done", 32'(done[idx]), 32'd0);
        return;
      end
      start[idx] = pulse_start && busy[idx] && ($urandom_range(0, 3) == 0);
      if (gap_left > 0) begin
        gap_left--;
        s_valid[idx] = 1'b0;
      end else if (wi < plan.size()) begin
        s_valid[idx] = 1'b1;
        s_data[idx]  = plan[wi];
      end else begin
        s_valid[idx] = 1'b0;
      end
      if (s_valid[idx] && s_ready[idx]) begin
        accepted++;
        wi++;
        gap_left = rand_gap ? $urandom_range(0, gap) : gap;
      end
      @(negedge clk);
    end
    start[idx]   = 1'b0;
    s_valid[idx] = 1'b0;

    check_eq("done_seen", 32'(got_done), 32'd1);
    if (got_done) begin
`ifdef CCFF_VERIFY_EN
      check_eq("shift_count", 32'(nce), 32'(2 * len));
      check_eq("err_at_done", 32'(err[idx]), 32'(force_t && any_one));
`else
      check_eq("shift_count", 32'(nce), 32'(len));
      check_eq("err_at_done", 32'(err[idx]), 32'd0);
`endif
      check_eq("done_latency", 32'(done_cyc), 32'(last_ce + 1));
      check_eq("done_busy_ce", 32'({busy[idx], config_enable[idx]}), 32'd0);
      check_eq("done_bc", 32'(get_bc(idx)), 32'(len));
      check_eq("words_taken", 32'(accepted), 32'(need_words));
      if (gap == 0) check_eq("no_bubble", 32'(last_ce - first_ce + 1), 32'(nce));
      if (!force_t) check_eq("chain", 32'(chain[idx] & mask), 32'(exp_chain));
      @(negedge clk);
      check_eq("done_once", 32'({done[idx], busy[idx]}), 32'd0);
    end
    force0[idx] = 1'b0;
  endtask

  initial begin
    int idx, nw, len;
    pReset = '1; start = '0; s_valid = '0; s_data = '0; force0 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("reset_outs", 32'({s_ready[i], config_enable[i], ccff_head[i],
                                  busy[i], done[i], err[i]}), 32'd0);
      check_eq("reset_bc", 32'(get_bc(i)), 32'd0);
    end
    pReset = '0;

    plan = '{8'hA5, 8'h5A};         run_load(0, 0, 1'b0, 1'b0, 1'b0, 0);
    plan = '{8'hFF, 8'h03, 8'h77};  run_load(1, 0, 1'b0, 1'b0, 1'b0, 0);
    plan = '{8'hFF, 8'h03};         run_load(1, 5, 1'b0, 1'b0, 1'b0, 0);
    plan = '{8'hA5};                run_load(0, 0, 1'b0, 1'b0, 1'b0, 2);
    plan = '{8'hA5, 8'h5A};         run_load(0, 0, 1'b0, 1'b0, 1'b0, 0);
    plan = '{8'hA5};                run_load(0, 0, 1'b0, 1'b1, 1'b0, 0);
`ifdef CCFF_VERIFY_EN
    plan = '{8'hA5};                run_load(0, 0, 1'b0, 1'b0, 1'b1, 0);
`endif

    repeat (24) begin
      idx = int'($urandom_range(0, 1));
      len = (idx == 0) ? LEN0 : LEN1;
      nw  = (len + 7) / 8 + int'($urandom_range(0, 1));
      plan.delete();
      for (int k = 0; k < nw; k++) plan.push_back(8'($urandom));
      run_load(idx, int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)),
`ifdef CCFF_VERIFY_EN
               ($urandom_range(0, 3) == 0),
`else
               1'b0,
`endif
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, len - 1)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
